// File: rtl/jacobi_operand_sel_if.sv
// Operand/result bus between the Jacobi iteration controller and its environment.
// master is the controller side; slave is the rotation datapath / sequencer side.
interface jacobi_operand_sel_if #(
   parameter int W  = 21,
   parameter int N  = 6,
   parameter int CW = 3
);
   logic             start;
   logic [N*W-1:0]   init_data;
   logic             fb_valid;
   logic [N*W-1:0]   fb_data;
   logic             out_ready;
   logic             out_valid;
   logic [N*W-1:0]   out_data;
   logic             sel_fb;
   logic [CW-1:0]    iter_cnt;
   logic             busy;
   logic             done;

   modport master (
      input  start, init_data, fb_valid, fb_data, out_ready,
      output out_valid, out_data, sel_fb, iter_cnt, busy, done
   );

   modport slave (
      output start, init_data, fb_valid, fb_data, out_ready,
      input  out_valid, out_data, sel_fb, iter_cnt, busy, done
   );
endinterface

// File: rtl/jacobi_operand_sel.sv
// Operand select and pass controller for the covariance-eigen Jacobi stage:
// issues initial lanes, recirculates datapath results, stops on pass limit or convergence.
module jacobi_operand_sel #(
   parameter int             W        = 21,
   parameter int             N        = 6,
   parameter int             MAX_ITER = 6,
   parameter int             CW       = 3,
   parameter logic [N-1:0]   OFF_MASK = 6'b010110,
   parameter logic [W-1:0]   THRESH   = '0
) (
   input logic                    clk,
   input logic                    rst_n,
   jacobi_operand_sel_if.master   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [W:0]    THRESH_EXT = {1'b0, THRESH};
   localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_ITER);

   state_t            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [N*W-1:0]    out_data_q, out_data_d;
   logic              sel_fb_q, sel_fb_d;
   logic [CW-1:0]     iter_cnt_q, iter_cnt_d;
   logic              done_q, done_d;

   logic [N-1:0]      lane_ok;
   logic              converged;
   logic [CW-1:0]     iter_next;

   // Magnitude is taken one bit wider so the most negative lane value stays large.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [W:0] lane_ext;
         logic [W:0] lane_abs;
         assign lane_ext    = {bus.fb_data[gi*W + W - 1], bus.fb_data[gi*W +: W]};
         assign lane_abs    = lane_ext[W] ? (~lane_ext + 1'b1) : lane_ext;
         assign lane_ok[gi] = ~OFF_MASK[gi] | (lane_abs < THRESH_EXT);
      end
   endgenerate

   assign converged = (THRESH_EXT != '0) && (&lane_ok);
   assign iter_next = iter_cnt_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sel_fb_d    = sel_fb_q;
      iter_cnt_d  = iter_cnt_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               out_data_d  = bus.init_data;
               sel_fb_d    = 1'b0;
               iter_cnt_d  = '0;
               out_valid_d = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.fb_valid) begin
               out_data_d = bus.fb_data;
               sel_fb_d   = 1'b1;
               iter_cnt_d = iter_next;
               if ((iter_next == MAX_CNT) || converged) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  out_valid_d = 1'b1;
                  state_d     = ST_ISSUE;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sel_fb_q    <= 1'b0;
         iter_cnt_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sel_fb_q    <= sel_fb_d;
         iter_cnt_q  <= iter_cnt_d;
         done_q      <= done_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel_fb    = sel_fb_q;
   assign bus.iter_cnt  = iter_cnt_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_jacobi_operand_sel.sv
// Directed bench: three controllers (THRESH 0, 4, 1) share one stimulus stream,
// each scenario starts from reset and checks the relevant instance inline.
module tb_jacobi_operand_sel;

   localparam int W  = 21;
   localparam int N  = 6;
   localparam int CW = 3;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             fb_valid;
   logic             out_ready;
   logic [N*W-1:0]   init_data;
   logic [N*W-1:0]   fb_data;

   int n_checks;
   int n_fail;

   jacobi_operand_sel_if #(.W(W), .N(N), .CW(CW)) if0 ();
   jacobi_operand_sel_if #(.W(W), .N(N), .CW(CW)) if4 ();
   jacobi_operand_sel_if #(.W(W), .N(N), .CW(CW)) if1 ();

   assign if0.start = start;  assign if0.fb_valid = fb_valid;  assign if0.out_ready = out_ready;
   assign if0.init_data = init_data;  assign if0.fb_data = fb_data;
   assign if4.start = start;  assign if4.fb_valid = fb_valid;  assign if4.out_ready = out_ready;
   assign if4.init_data = init_data;  assign if4.fb_data = fb_data;
   assign if1.start = start;  assign if1.fb_valid = fb_valid;  assign if1.out_ready = out_ready;
   assign if1.init_data = init_data;  assign if1.fb_data = fb_data;

   jacobi_operand_sel #(.W(W), .N(N), .MAX_ITER(6), .CW(CW), .OFF_MASK(6'b010110), .THRESH(21'd0))
      u_t0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   jacobi_operand_sel #(.W(W), .N(N), .MAX_ITER(6), .CW(CW), .OFF_MASK(6'b010110), .THRESH(21'd4))
      u_t4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   jacobi_operand_sel #(.W(W), .N(N), .MAX_ITER(6), .CW(CW), .OFF_MASK(6'b010110), .THRESH(21'd1))
      u_t1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5);
      logic [N*W-1:0] v;
      v = {W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; fb_valid = 1'b0; out_ready = 1'b0;
      init_data = '0; fb_data = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_start(input logic [N*W-1:0] d);
      init_data = d; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic feed(input logic [N*W-1:0] d);
      fb_data = d; fb_valid = 1'b1;
      tick();
      fb_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", if0.out_valid); end
      n_checks++; if (if0.out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", if0.out_data); end
      n_checks++; if (if0.sel_fb !== 1'b0) begin n_fail++; $display("FAIL rst_sel_fb: got %b want 0", if0.sel_fb); end
      n_checks++; if (if0.iter_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_iter_cnt: got %0d want 0", if0.iter_cnt); end
      n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", if0.busy); end
      n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", if0.done); end
      // stray fb_valid in IDLE
      feed(pack(9, 9, 9, 9, 9, 9));
      n_checks++; if (if0.busy !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.out_data !== '0)
         begin n_fail++; $display("FAIL idle_fb_ignored: busy=%b iter=%0d data=%h want 0/0/0", if0.busy, if0.iter_cnt, if0.out_data); end
      $display("test_reset done");
   endtask

   task automatic test_reset_midrun();
      do_reset();
      out_ready = 1'b1;
      do_start(pack(1, 2, 3, 4, 5, 6));
      tick(); feed(pack(10, 100, 100, 10, 100, 10));
      tick(); feed(pack(20, 200, 200, 20, 200, 20));
      tick();
      n_checks++; if (if0.iter_cnt !== 3'd2 || if0.out_valid !== 1'b0 || if0.busy !== 1'b1)
         begin n_fail++; $display("FAIL midrun_wait: iter=%0d valid=%b busy=%b want 2/0/1", if0.iter_cnt, if0.out_valid, if0.busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (if0.busy !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.sel_fb !== 1'b0 || if0.out_data !== '0)
         begin n_fail++; $display("FAIL async_reset: busy=%b iter=%0d sel=%b data=%h want all 0", if0.busy, if0.iter_cnt, if0.sel_fb, if0.out_data); end
      fb_valid = 1'b1;
      tick();
      n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: got %b want 0", if0.done); end
      rst_n = 1'b1; fb_valid = 1'b0;
      tick();
      n_checks++; if (if0.done !== 1'b0 || if0.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: done=%b busy=%b want 0/0", if0.done, if0.busy); end
      do_start(pack(7, 7, 7, 7, 7, 7));
      n_checks++; if (if0.out_valid !== 1'b1 || if0.sel_fb !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.out_data !== pack(7, 7, 7, 7, 7, 7))
         begin n_fail++; $display("FAIL restart_after_reset: valid=%b sel=%b iter=%0d data=%h", if0.out_valid, if0.sel_fb, if0.iter_cnt, if0.out_data); end
      $display("test_reset_midrun done");
   endtask

   task automatic test_first_pass();
      do_reset();
      out_ready = 1'b1;
      do_start(pack(100, -3, 7, 50, 2, 80));
      n_checks++; if (if0.out_valid !== 1'b1 || if0.sel_fb !== 1'b0 || if0.busy !== 1'b1)
         begin n_fail++; $display("FAIL first_ctrl: valid=%b sel=%b busy=%b want 1/0/1", if0.out_valid, if0.sel_fb, if0.busy); end
      n_checks++; if (if0.out_data !== pack(100, -3, 7, 50, 2, 80))
         begin n_fail++; $display("FAIL first_data: got %h want %h", if0.out_data, pack(100, -3, 7, 50, 2, 80)); end
      tick();
      n_checks++; if (if0.out_valid !== 1'b0 || if0.busy !== 1'b1)
         begin n_fail++; $display("FAIL first_handshake: valid=%b busy=%b want 0/1", if0.out_valid, if0.busy); end
      $display("test_first_pass done");
   endtask

   task automatic test_iter_limit();
      do_reset();
      out_ready = 1'b1;
      do_start(pack(1, 2, 3, 4, 5, 6));
      for (int p = 1; p <= 6; p++) begin
         n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL iter_issue%0d: valid=%b want 1", p, if0.out_valid); end
         tick();
         feed(pack(p, 1000 + p, -(1000 + p), 7 * p, 500, 9));
         if (p < 6) begin
            n_checks++; if (if0.done !== 1'b0 || if0.iter_cnt !== CW'(p) || if0.sel_fb !== 1'b1)
               begin n_fail++; $display("FAIL iter_pass%0d: done=%b iter=%0d sel=%b want 0/%0d/1", p, if0.done, if0.iter_cnt, if0.sel_fb, p); end
         end else begin
            n_checks++; if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.out_valid !== 1'b0 || if0.iter_cnt !== 3'd6)
               begin n_fail++; $display("FAIL iter_done: done=%b busy=%b valid=%b iter=%0d want 1/0/0/6", if0.done, if0.busy, if0.out_valid, if0.iter_cnt); end
            n_checks++; if (if0.out_data !== pack(6, 1006, -1006, 42, 500, 9))
               begin n_fail++; $display("FAIL iter_final_data: got %h want %h", if0.out_data, pack(6, 1006, -1006, 42, 500, 9)); end
         end
         $display("iter pass %0d iter_cnt=%0d done=%b", p, if0.iter_cnt, if0.done);
      end
      tick();
      n_checks++; if (if0.done !== 1'b0 || if0.out_valid !== 1'b0 || if0.iter_cnt !== 3'd6 || if0.sel_fb !== 1'b1 || if0.out_data !== pack(6, 1006, -1006, 42, 500, 9))
         begin n_fail++; $display("FAIL post_done_hold: done=%b valid=%b iter=%0d sel=%b data=%h", if0.done, if0.out_valid, if0.iter_cnt, if0.sel_fb, if0.out_data); end
      do_start(pack(5, 5, 5, 5, 5, 5));
      n_checks++; if (if0.out_valid !== 1'b1 || if0.sel_fb !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.out_data !== pack(5, 5, 5, 5, 5, 5))
         begin n_fail++; $display("FAIL restart_after_done: valid=%b sel=%b iter=%0d data=%h", if0.out_valid, if0.sel_fb, if0.iter_cnt, if0.out_data); end
      $display("test_iter_limit done");
   endtask

   task automatic test_converge();
      do_reset();
      out_ready = 1'b1;
      do_start(pack(1, 2, 3, 4, 5, 6));
      tick(); feed(pack(10, 5, -6, 20, 9, 30));
      n_checks++; if (if4.done !== 1'b0 || if4.out_valid !== 1'b1 || if4.iter_cnt !== 3'd1)
         begin n_fail++; $display("FAIL conv_pass1: done=%b valid=%b iter=%0d want 0/1/1", if4.done, if4.out_valid, if4.iter_cnt); end
      tick(); feed(pack(11, 3, -2, 22, 0, 33));
      n_checks++; if (if4.done !== 1'b1 || if4.iter_cnt !== 3'd2 || if4.busy !== 1'b0 || if4.out_data !== pack(11, 3, -2, 22, 0, 33))
         begin n_fail++; $display("FAIL conv_done: done=%b iter=%0d busy=%b data=%h want 1/2/0", if4.done, if4.iter_cnt, if4.busy, if4.out_data); end
      n_checks++; if (if0.done !== 1'b0 || if0.out_valid !== 1'b1)
         begin n_fail++; $display("FAIL thresh0_no_exit: done=%b valid=%b want 0/1", if0.done, if0.out_valid); end
      do_reset();
      out_ready = 1'b1;
      do_start(pack(1, 2, 3, 4, 5, 6));
      tick(); feed(pack(0, -4, 0, 0, 0, 0));
      n_checks++; if (if4.done !== 1'b0 || if4.out_valid !== 1'b1 || if4.iter_cnt !== 3'd1)
         begin n_fail++; $display("FAIL conv_boundary_m4: done=%b valid=%b iter=%0d want 0/1/1", if4.done, if4.out_valid, if4.iter_cnt); end
      $display("test_converge done");
   endtask

   task automatic test_extreme_neg();
      do_reset();
      out_ready = 1'b1;
      do_start(pack(1, 2, 3, 4, 5, 6));
      for (int p = 1; p <= 6; p++) begin
         tick();
         feed(pack(0, -1048576, 0, 0, 0, 0));
         n_checks++; if (if1.done !== (p == 6) || if1.iter_cnt !== CW'(p))
            begin n_fail++; $display("FAIL extreme_pass%0d: done=%b iter=%0d want %0d/%0d", p, if1.done, if1.iter_cnt, (p == 6), p); end
         $display("extreme pass %0d iter_cnt=%0d done=%b", p, if1.iter_cnt, if1.done);
      end
      $display("test_extreme_neg done");
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      do_start(pack(100, -3, 7, 50, 2, 80));
      for (int c = 0; c < 10; c++) begin
         fb_valid = c[0]; start = ~c[0];
         init_data = pack(c, c, c, c, c, c);
         fb_data = pack(1, 1, 1, 1, 1, 1);
         tick();
         n_checks++; if (if0.out_valid !== 1'b1 || if0.sel_fb !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.busy !== 1'b1 || if0.out_data !== pack(100, -3, 7, 50, 2, 80))
            begin n_fail++; $display("FAIL bp_hold%0d: valid=%b sel=%b iter=%0d busy=%b data=%h", c, if0.out_valid, if0.sel_fb, if0.iter_cnt, if0.busy, if0.out_data); end
      end
      fb_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
      tick();
      n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid=%b want 0", if0.out_valid); end
      tick();
      n_checks++; if (if0.out_valid !== 1'b0 || if0.iter_cnt !== 3'd0 || if0.busy !== 1'b1)
         begin n_fail++; $display("FAIL bp_wait: valid=%b iter=%0d busy=%b want 0/0/1", if0.out_valid, if0.iter_cnt, if0.busy); end
      $display("test_backpressure done");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; start = 1'b0; fb_valid = 1'b0; out_ready = 1'b0;
      init_data = '0; fb_data = '0;
      test_reset();
      test_reset_midrun();
      test_first_pass();
      test_iter_limit();
      test_converge();
      test_extreme_neg();
      test_backpressure();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
